// File: rtl/single_core_processor.sv
// Matrix-multiply engine: C = A x B from an internal RAM, one MAC per three cycles.
// Define MAC_SATURATE_EN for unsigned saturating products/sums instead of wrap.
module single_core_processor #(
    parameter  int W      = 16,
    parameter  int M      = 2,
    parameter  int K      = 3,
    parameter  int N      = 2,
    parameter  int DEPTH  = 64,
    parameter  int A_BASE = 0,
    parameter  int B_BASE = 16,
    parameter  int C_BASE = 32,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          status,
    output logic          end_process,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [W-1:0]  ld_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [W-1:0]  dbg_data
);

    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam int JW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_MAC,
        S_WR,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  i_q, i_d;
    logic [JW-1:0]  j_q, j_d;
    logic [KW-1:0]  k_q, k_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   a_q, a_d;
    logic           end_q, end_d;
    logic [W-1:0]   dbg_q;
    logic [W-1:0]   rdata_q;

    logic [W-1:0]   mem [DEPTH];

    logic [AW-1:0]  a_addr, b_addr, c_addr;
    logic [AW-1:0]  port_addr;
    logic           port_we;
    logic [W-1:0]   port_wdata;
    logic [W-1:0]   mac_res;

    assign a_addr = AW'(A_BASE) + AW'(i_q) * AW'(K) + AW'(k_q);
    assign b_addr = AW'(B_BASE) + AW'(k_q) * AW'(N) + AW'(j_q);
    assign c_addr = AW'(C_BASE) + AW'(i_q) * AW'(N) + AW'(j_q);

`ifdef MAC_SATURATE_EN
    logic [2*W-1:0] prod_full;
    logic [W-1:0]   prod_sat;
    logic [W:0]     sum_ext;

    always_comb begin
        prod_full = a_q * rdata_q;
        prod_sat  = (|prod_full[2*W-1:W]) ? '1 : prod_full[W-1:0];
        sum_ext   = {1'b0, acc_q} + {1'b0, prod_sat};
        mac_res   = sum_ext[W] ? '1 : sum_ext[W-1:0];
    end
`else
    always_comb begin
        mac_res = acc_q + W'(a_q * rdata_q);
    end
`endif

    // Engine and loader share one RAM port; the loader only owns it when idle.
    always_comb begin
        port_addr  = ld_addr;
        port_we    = 1'b0;
        port_wdata = ld_data;
        unique case (state_q)
            S_RD_A: port_addr = a_addr;
            S_RD_B: port_addr = b_addr;
            S_WR: begin
                port_addr  = c_addr;
                port_we    = 1'b1;
                port_wdata = acc_q;
            end
            S_IDLE, S_DONE: port_we = ld_en;
            default: port_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (port_we) begin
            mem[port_addr] <= port_wdata;
        end
        rdata_q <= mem[port_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_q <= '0;
        end else begin
            dbg_q <= mem[dbg_addr];
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        a_d     = a_q;
        unique case (state_q)
            S_IDLE: begin
                if (status) begin
                    state_d = S_RD_A;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            S_RD_A: state_d = S_RD_B;
            S_RD_B: begin
                a_d     = rdata_q;
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_d = mac_res;
                if (k_q == KW'(K - 1)) begin
                    state_d = S_WR;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = S_RD_A;
                end
            end
            S_WR: begin
                acc_d   = '0;
                k_d     = '0;
                state_d = S_RD_A;
                if (j_q == JW'(N - 1)) begin
                    j_d = '0;
                    if (i_q == IW'(M - 1)) begin
                        i_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_DONE: begin
                if (!status) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        end_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            end_q   <= end_d;
        end
    end

    assign end_process = end_q;
    assign dbg_data    = dbg_q;

endmodule

// File: tb/tb_single_core_processor.sv
// Randomized bench for single_core_processor with a behavioural matrix model.
// Honors MAC_SATURATE_EN the same way as the design.
module tb_single_core_processor;

    localparam int W     = 16;
    localparam int M     = 2;
    localparam int K     = 3;
    localparam int N     = 2;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int AB    = 0;
    localparam int BB    = 16;
    localparam int CB    = 32;
    localparam int ELEM  = 3 * K + 1;
    localparam int CYC   = M * N * ELEM;

    logic          clk = 1'b0;
    logic          clk_en = 1'b0;
    logic          rst = 1'b0;
    logic          status = 1'b0;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [W-1:0]  ld_data = '0;
    logic [AW-1:0] dbg_addr = '0;
    logic          end_process;
    logic [W-1:0]  dbg_data;

    int pass_cnt = 0;
    int chk_cnt = 0;

    single_core_processor dut (
        .clk         (clk),
        .rst         (rst),
        .status      (status),
        .end_process (end_process),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Behavioural model
    logic [W-1:0] mm [DEPTH];
    bit           mv [DEPTH];
    logic [W-1:0] cres [M*N];
    int           cnt = 0;
    bit           busy = 0;
    bit           done = 0;
    logic         exp_end = 1'b0;
    logic [W-1:0] exp_dbg = '0;
    bit           exp_dbg_v = 0;

    function automatic logic [W-1:0] mac(logic [W-1:0] acc, logic [W-1:0] a,
                                         logic [W-1:0] b);
        int unsigned p;
        int unsigned s;
        p = 32'(a) * 32'(b);
`ifdef MAC_SATURATE_EN
        if (p > 32'hFFFF) p = 32'hFFFF;
        s = 32'(acc) + p;
        if (s > 32'hFFFF) s = 32'hFFFF;
`else
        s = 32'(acc) + p;
`endif
        return W'(s);
    endfunction

    task automatic compute();
        logic [W-1:0] acc;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = '0;
                for (int k = 0; k < K; k++) begin
                    acc = mac(acc, mm[AB + i*K + k], mm[BB + k*N + j]);
                end
                cres[i*N + j] = acc;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            busy = 0;
            done = 0;
            exp_end = 1'b0;
            exp_dbg = '0;
            exp_dbg_v = 1;
        end else begin
            exp_dbg = mm[dbg_addr];
            exp_dbg_v = mv[dbg_addr];
            if (busy) begin
                cnt++;
                if (cnt % ELEM == 0) begin
                    mm[CB + cnt/ELEM - 1] = cres[cnt/ELEM - 1];
                    mv[CB + cnt/ELEM - 1] = 1;
                end
                if (cnt == CYC) begin
                    busy = 0;
                    done = 1;
                    exp_end = 1'b1;
                end
            end else begin
                if (ld_en) begin
                    mm[ld_addr] = ld_data;
                    mv[ld_addr] = 1;
                end
                if (done) begin
                    if (!status) begin
                        done = 0;
                        exp_end = 1'b0;
                    end
                end else if (status) begin
                    compute();
                    busy = 1;
                    cnt = 0;
                end
            end
        end
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check("end_process", 32'(end_process), 32'(exp_end));
            if (exp_dbg_v) check("dbg_data", 32'(dbg_data), 32'(exp_dbg));
        end
    end

    task automatic load(int a, int d);
        ld_en = 1'b1;
        ld_addr = AW'(a);
        ld_data = W'(d);
        dbg_addr = AW'($urandom);
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic peek(int a, int exp, string nm);
        dbg_addr = AW'(a);
        @(negedge clk);
        check(nm, 32'(dbg_data), 32'(exp));
    endtask

    task automatic stop();
        status = 1'b0;
        @(negedge clk);
        check("leave_done", 32'(end_process), 32'd0);
    endtask

    task automatic load_basic();
        for (int a = 0; a < M*K; a++) load(AB + a, a + 1);
        for (int b = 0; b < K*N; b++) load(BB + b, b + 7);
    endtask

    task automatic run(string nm, bit noisy);
        int n;
        n = 0;
        status = 1'b1;
        do begin
            @(negedge clk);
            n++;
            dbg_addr = AW'($urandom);
            if (noisy && n < 30) begin
                status = 1'($urandom);
                ld_en = 1'($urandom);
                ld_addr = AW'($urandom);
                ld_data = W'($urandom);
                if (n == 5) begin
                    ld_en = 1'b1;
                    ld_addr = '0;
                    ld_data = 16'hAAAA;
                end
            end else begin
                ld_en = 1'b0;
                status = 1'b1;
            end
        end while (!end_process && n < 200);
        ld_en = 1'b0;
        status = 1'b1;
        check(nm, 32'(n - 1), 32'(CYC));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b1;
        #1 check("rst_end", 32'(end_process), 32'd0);
        check("rst_dbg", 32'(dbg_data), 32'd0);
        #1 rst = 1'b0;
        clk_en = 1'b1;
        for (int a = 0; a < DEPTH; a++) load(a, 0);

        clk_en = 1'b0;
        #20;
        dbg_addr = '0;
        rst = 1'b1;
        #1 check("rst_stopped_end", 32'(end_process), 32'd0);
        rst = 1'b0;
        #1 clk_en = 1'b1;
        peek(0, 0, "rst_dbg_after_clk");

        load_basic();
        run("lat_basic", 1'b1);
        peek(CB + 0, 58, "c00");
        peek(CB + 1, 64, "c01");
        peek(CB + 2, 139, "c10");
        peek(CB + 3, 154, "c11");
        peek(0, 1, "busy_load_ignored");

        repeat (5) @(negedge clk);
        check("hold_end", 32'(end_process), 32'd1);
        peek(CB + 0, 58, "hold_c00");
        stop();
        run("lat_again", 1'b0);
        peek(CB + 3, 154, "again_c11");
        stop();

        for (int a = 0; a < M*K; a++) load(AB + a, (a == 0) ? 256 : 0);
        for (int b = 0; b < K*N; b++) load(BB + b, (b == 0) ? 256 : 0);
        run("lat_ovf", 1'b0);
`ifdef MAC_SATURATE_EN
        peek(CB + 0, 16'hFFFF, "ovf_c00");
`else
        peek(CB + 0, 0, "ovf_c00");
`endif
        peek(CB + 1, 0, "ovf_c01");
        stop();

        load_basic();
        status = 1'b1;
        repeat (15) @(negedge clk);
        status = 1'b0;
        #2 rst = 1'b1;
        #1 check("midrst_end", 32'(end_process), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        peek(CB + 0, 58, "midrst_c00_kept");
        peek(CB + 1, 0, "midrst_c01_old");
        run("lat_midrst", 1'b1);
        peek(CB + 1, 64, "midrst_c01");
        peek(CB + 2, 139, "midrst_c10");

        repeat (6) begin
            stop();
            for (int a = 0; a < M*K + K*N; a++) begin
                load((a < M*K) ? AB + a : BB + a - M*K,
                     $urandom_range(0, 1) ? int'($urandom_range(0, 65535))
                                          : int'($urandom_range(0, 255)));
            end
            run("lat_rand", 1'b1);
            for (int c = 0; c < M*N; c++) begin
                dbg_addr = AW'(CB + c);
                @(negedge clk);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
